rtsnoc_local_port_buffer: RTL and testbench

- Elastic buffer between the local NoC interface of the AXI4-Lite/Wishbone RTSNoC proxy and the router local port.
- TX FIFO absorbs proxy flits while the router asserts wait; RX FIFO prefetches router flits so the proxy sees back-to-back data.
- Proxy-side ports mimic a router local port; router-side ports mimic a proxy.
- Single clock domain.

---
 rtl/rtsnoc_local_port_buffer_pkg.sv | 18 +
 rtl/rtsnoc_sync_fifo.sv | 54 +++++
 rtl/rtsnoc_local_port_buffer.sv | 94 +++++++++
 tb/tb_rtsnoc_local_port_buffer.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rtsnoc_local_port_buffer_pkg.sv
// Shared types and bus-width derivation for the RTSNoC local port buffer.
package rtsnoc_local_port_buffer_pkg;

  typedef enum logic {
    RX_IDLE = 1'b0,
    RX_GAP  = 1'b1
  } rx_state_t;

  // Flit header: two X coords, two Y coords, local port ids and control bits.
  function automatic int noc_header_size(input int size_x, input int size_y);
    return 2 * size_x + 2 * size_y + 6;
  endfunction

  function automatic int noc_bus_size(input int data_width, input int size_x, input int size_y);
    return data_width + noc_header_size(size_x, size_y);
  endfunction

endpackage

// File: rtl/rtsnoc_sync_fifo.sv
// First-word-fall-through FIFO; push visible on dout one cycle later, dout forced to 0 when empty.
// Push while full and pop while empty are ignored; caller reads full/empty for flow control.
module rtsnoc_sync_fifo #(
  parameter int WIDTH      = 26,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [WIDTH-1:0]      din,
  input  logic                  pop,
  output logic [WIDTH-1:0]      dout,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   level
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_LEVEL = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  // Full is judged on the registered level, so a same-cycle pop never frees a slot.
  assign full    = (level == FULL_LEVEL);
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/rtsnoc_local_port_buffer.sv
// Elastic TX/RX buffering between proxy and router local port; 1-cycle fall-through each way.
// p_wait_o holds the proxy when TX is full; RX fetches at most every other cycle and stops when full.
module rtsnoc_local_port_buffer
  import rtsnoc_local_port_buffer_pkg::*;
#(
  parameter int SOC_SIZE_X     = 1,
  parameter int SOC_SIZE_Y     = 1,
  parameter int NOC_DATA_WIDTH = 16,
  parameter int TX_DEPTH_LOG2  = 2,
  parameter int RX_DEPTH_LOG2  = 2,
  localparam int NOC_BUS_SIZE  = noc_bus_size(NOC_DATA_WIDTH, SOC_SIZE_X, SOC_SIZE_Y)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NOC_BUS_SIZE-1:0]  p_din_i,
  input  logic                     p_wr_i,
  output logic                     p_wait_o,
  output logic [NOC_BUS_SIZE-1:0]  p_dout_o,
  output logic                     p_nd_o,
  input  logic                     p_rd_i,
  output logic [NOC_BUS_SIZE-1:0]  r_din_o,
  output logic                     r_wr_o,
  input  logic                     r_wait_i,
  input  logic [NOC_BUS_SIZE-1:0]  r_dout_i,
  input  logic                     r_nd_i,
  output logic                     r_rd_o,
  output logic [TX_DEPTH_LOG2:0]   tx_level_o,
  output logic [RX_DEPTH_LOG2:0]   rx_level_o,
  output logic                     ovf_o
);

  logic      tx_empty;
  logic      rx_full;
  logic      rx_empty;
  rx_state_t rx_state;

  rtsnoc_sync_fifo #(
    .WIDTH      (NOC_BUS_SIZE),
    .DEPTH_LOG2 (TX_DEPTH_LOG2)
  ) u_tx_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (p_wr_i),
    .din   (p_din_i),
    .pop   (r_wr_o && !r_wait_i),
    .dout  (r_din_o),
    .full  (p_wait_o),
    .empty (tx_empty),
    .level (tx_level_o)
  );

  rtsnoc_sync_fifo #(
    .WIDTH      (NOC_BUS_SIZE),
    .DEPTH_LOG2 (RX_DEPTH_LOG2)
  ) u_rx_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (r_rd_o),
    .din   (r_dout_i),
    .pop   (p_rd_i),
    .dout  (p_dout_o),
    .full  (rx_full),
    .empty (rx_empty),
    .level (rx_level_o)
  );

  assign r_wr_o = !tx_empty;
  assign p_nd_o = !rx_empty;

  // Reset gates the strobe so the router never sees a pop while we are held in reset.
  assign r_rd_o = !rst_i && (rx_state == RX_IDLE) && r_nd_i && !rx_full;

  // GAP gives the router one cycle to refresh r_nd_i after each pop.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_state <= RX_IDLE;
    end else begin
      case (rx_state)
        RX_IDLE: if (r_rd_o) rx_state <= RX_GAP;
        RX_GAP:  rx_state <= RX_IDLE;
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ovf_o <= 1'b0;
    end else if ((p_wr_i && p_wait_o) || (p_rd_i && rx_empty)) begin
      ovf_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rtsnoc_local_port_buffer.sv
// Directed self-checking bench for rtsnoc_local_port_buffer.
module tb_rtsnoc_local_port_buffer;

  localparam int W = 26;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic [W-1:0] p_din_i;
  logic         p_wr_i;
  logic         p_wait_o;
  logic [W-1:0] p_dout_o;
  logic         p_nd_o;
  logic         p_rd_i;
  logic [W-1:0] r_din_o;
  logic         r_wr_o;
  logic         r_wait_i;
  logic [W-1:0] r_dout_i;
  logic         r_nd_i;
  logic         r_rd_o;
  logic [2:0]   tx_level_o;
  logic [2:0]   rx_level_o;
  logic         ovf_o;

  int n_checks = 0;
  int n_fail   = 0;

  rtsnoc_local_port_buffer dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .p_din_i    (p_din_i),
    .p_wr_i     (p_wr_i),
    .p_wait_o   (p_wait_o),
    .p_dout_o   (p_dout_o),
    .p_nd_o     (p_nd_o),
    .p_rd_i     (p_rd_i),
    .r_din_o    (r_din_o),
    .r_wr_o     (r_wr_o),
    .r_wait_i   (r_wait_i),
    .r_dout_i   (r_dout_i),
    .r_nd_i     (r_nd_i),
    .r_rd_o     (r_rd_o),
    .tx_level_o (tx_level_o),
    .rx_level_o (rx_level_o),
    .ovf_o      (ovf_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset;
    rst_i = 1'b1; p_din_i = '0; p_wr_i = 1'b0; p_rd_i = 1'b0;
    r_wait_i = 1'b0; r_dout_i = '0; r_nd_i = 1'b0;
    tick(); tick();
    rst_i = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    rst_i = 1'b1; p_din_i = 26'h3ABCDEF; p_wr_i = 1'b1; p_rd_i = 1'b1;
    r_wait_i = 1'b0; r_dout_i = 26'h1234567; r_nd_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_checks++;
      if ({p_wait_o, p_nd_o, r_wr_o, r_rd_o, ovf_o, tx_level_o, rx_level_o} !== 11'd0 ||
          p_dout_o !== '0 || r_din_o !== '0) begin
        n_fail++;
        $display("FAIL reset_outputs cyc%0d: wait=%b nd=%b wr=%b rd=%b ovf=%b txl=%0d rxl=%0d pd=%h rd=%h, want all 0",
                 c, p_wait_o, p_nd_o, r_wr_o, r_rd_o, ovf_o, tx_level_o, rx_level_o, p_dout_o, r_din_o);
      end
    end
    p_wr_i = 1'b0; p_rd_i = 1'b0; r_nd_i = 1'b0;
    rst_i = 1'b0;
    #1;
  endtask

  task automatic test_tx_full;
    do_reset();
    r_wait_i = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      p_din_i = W'(i); p_wr_i = 1'b1;
      tick();
      if (i == 4) begin
        n_checks++;
        if (p_wait_o !== 1'b1 || tx_level_o !== 3'd4) begin
          n_fail++;
          $display("FAIL tx_full_level: wait=%b level=%0d, want wait=1 level=4", p_wait_o, tx_level_o);
        end
      end
    end
    p_wr_i = 1'b0;
    #1;
    n_checks++;
    if (ovf_o !== 1'b1 || tx_level_o !== 3'd4) begin
      n_fail++;
      $display("FAIL tx_drop_ovf: ovf=%b level=%0d, want ovf=1 level=4", ovf_o, tx_level_o);
    end
    r_wait_i = 1'b0;
    #1;
    for (int i = 1; i <= 4; i++) begin
      n_checks++;
      if (r_wr_o !== 1'b1 || r_din_o !== W'(i)) begin
        n_fail++;
        $display("FAIL tx_drain_%0d: wr=%b din=%h, want wr=1 din=%h", i, r_wr_o, r_din_o, W'(i));
      end
      tick();
    end
    n_checks++;
    if (r_wr_o !== 1'b0 || r_din_o !== '0 || tx_level_o !== 3'd0) begin
      n_fail++;
      $display("FAIL tx_drained: wr=%b din=%h level=%0d, want 0/0/0", r_wr_o, r_din_o, tx_level_o);
    end
  endtask

  task automatic test_tx_stream;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      p_din_i = 26'hA0 + W'(i); p_wr_i = 1'b1;
      tick();
      n_checks++;
      if (r_wr_o !== 1'b1 || r_din_o !== 26'hA0 + W'(i) || tx_level_o !== 3'd1) begin
        n_fail++;
        $display("FAIL tx_stream_%0d: wr=%b din=%h level=%0d, want wr=1 din=%h level=1",
                 i, r_wr_o, r_din_o, tx_level_o, 26'hA0 + W'(i));
      end
    end
    p_wr_i = 1'b0;
    tick();
    n_checks++;
    if (r_wr_o !== 1'b0 || tx_level_o !== 3'd0) begin
      n_fail++;
      $display("FAIL tx_stream_end: wr=%b level=%0d, want 0/0", r_wr_o, tx_level_o);
    end
  endtask

  task automatic test_rx_fetch;
    logic rd;
    do_reset();
    r_nd_i = 1'b1; r_dout_i = 26'h100;
    #1;
    for (int c = 0; c < 10; c++) begin
      rd = r_rd_o;
      n_checks++;
      if (rd !== ((c < 8) && (c % 2 == 0))) begin
        n_fail++;
        $display("FAIL rx_rd_cyc%0d: r_rd_o=%b, want %b", c, rd, (c < 8) && (c % 2 == 0));
      end
      tick();
      if (rd) r_dout_i = r_dout_i + 1'b1;
      #1;
    end
    n_checks++;
    if (rx_level_o !== 3'd4 || p_nd_o !== 1'b1 || p_dout_o !== 26'h100) begin
      n_fail++;
      $display("FAIL rx_full: level=%0d nd=%b dout=%h, want level=4 nd=1 dout=100", rx_level_o, p_nd_o, p_dout_o);
    end
    p_rd_i = 1'b1;
    tick();
    p_rd_i = 1'b0;
    #1;
    n_checks++;
    if (r_rd_o !== 1'b1 || rx_level_o !== 3'd3 || p_dout_o !== 26'h101) begin
      n_fail++;
      $display("FAIL rx_refetch: rd=%b level=%0d dout=%h, want rd=1 level=3 dout=101", r_rd_o, rx_level_o, p_dout_o);
    end
    tick();
    r_nd_i = 1'b0;
    #1;
    for (int i = 1; i <= 4; i++) begin
      n_checks++;
      if (p_nd_o !== 1'b1 || p_dout_o !== 26'h100 + W'(i)) begin
        n_fail++;
        $display("FAIL rx_drain_%0d: nd=%b dout=%h, want nd=1 dout=%h", i, p_nd_o, p_dout_o, 26'h100 + W'(i));
      end
      p_rd_i = 1'b1;
      tick();
    end
    p_rd_i = 1'b0;
    #1;
    n_checks++;
    if (p_nd_o !== 1'b0 || p_dout_o !== '0 || ovf_o !== 1'b0) begin
      n_fail++;
      $display("FAIL rx_drained: nd=%b dout=%h ovf=%b, want 0/0/0", p_nd_o, p_dout_o, ovf_o);
    end
  endtask

  task automatic test_rx_underflow;
    do_reset();
    p_rd_i = 1'b1;
    tick();
    p_rd_i = 1'b0;
    #1;
    n_checks++;
    if (ovf_o !== 1'b1 || rx_level_o !== 3'd0 || p_dout_o !== '0 || p_nd_o !== 1'b0) begin
      n_fail++;
      $display("FAIL rx_underflow: ovf=%b level=%0d dout=%h nd=%b, want ovf=1 level=0 dout=0 nd=0",
               ovf_o, rx_level_o, p_dout_o, p_nd_o);
    end
  endtask

  task automatic test_mid_reset;
    do_reset();
    r_wait_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      p_din_i = 26'h11 + W'(i); p_wr_i = 1'b1;
      tick();
    end
    p_wr_i = 1'b0;
    r_nd_i = 1'b1; r_dout_i = 26'h55;
    tick();
    r_nd_i = 1'b0;
    #1;
    n_checks++;
    if (tx_level_o !== 3'd3 || rx_level_o !== 3'd1) begin
      n_fail++;
      $display("FAIL midrst_pre: txl=%0d rxl=%0d, want 3/1", tx_level_o, rx_level_o);
    end
    rst_i = 1'b1;
    #1;
    n_checks++;
    if (tx_level_o !== 3'd0 || rx_level_o !== 3'd0 || r_wr_o !== 1'b0 || r_din_o !== '0 || p_nd_o !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_async: txl=%0d rxl=%0d wr=%b din=%h nd=%b, want all 0",
               tx_level_o, rx_level_o, r_wr_o, r_din_o, p_nd_o);
    end
    tick();
    rst_i = 1'b0; r_wait_i = 1'b0; r_nd_i = 1'b1; r_dout_i = 26'h66;
    #1;
    n_checks++;
    if (r_rd_o !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_fsm_idle: r_rd_o=%b, want 1", r_rd_o);
    end
    r_nd_i = 1'b0;
    p_din_i = 26'h77; p_wr_i = 1'b1;
    tick();
    p_wr_i = 1'b0;
    #1;
    n_checks++;
    if (r_wr_o !== 1'b1 || r_din_o !== 26'h77 || tx_level_o !== 3'd1) begin
      n_fail++;
      $display("FAIL midrst_first_flit: wr=%b din=%h level=%0d, want wr=1 din=77 level=1", r_wr_o, r_din_o, tx_level_o);
    end
    tick();
    n_checks++;
    if (r_wr_o !== 1'b0 || tx_level_o !== 3'd0) begin
      n_fail++;
      $display("FAIL midrst_single: wr=%b level=%0d, want 0/0", r_wr_o, tx_level_o);
    end
  endtask

  initial begin
    test_reset();
    test_tx_full();
    test_tx_stream();
    test_rx_fetch();
    test_rx_underflow();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
